// File: rtl/seq_array_multiplier_pkg.sv
// Shared types and helpers for the sequential array multiplier.
// Holds the FSM state enum and the iteration-counter width function.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_array_multiplier_if.sv
// Operand / result handshake bundle for seq_array_multiplier.
// The master drives operands and takes results; the slave is the multiplier.
interface seq_array_multiplier_if #(
  parameter int WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic               signed_md;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid,
    output signed_md,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  signed_md,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

endinterface

// File: rtl/seq_array_multiplier_fa_row.sv
// One WIDTH-bit ripple row of full adders, carry-in tied low.
// Produces the partial-product sum and the row carry-out.
module mul_fa_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (a[i] & c[i])
                  | (b[i] & c[i]);
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative WIDTH x WIDTH shift-add multiplier, unsigned or signed.
// One partial product per cycle through a single full-adder row.
module seq_array_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_array_multiplier_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t            state;
  // Bit 0 of the accumulator is never read back; it only
  // reaches the product through acc_nxt on the final step.
  logic [PW-1:1]     acc;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplr;
  logic              neg;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  addend;
  logic [WIDTH-1:0]  sum;
  logic              carry;
  logic [PW-1:0]     acc_nxt;
  logic              last;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic              neg_in;

  assign addend  = mplr[0] ? mcand : '0;
  assign acc_nxt = {carry, sum, acc[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  assign a_mag  = (bus.signed_md & bus.a[WIDTH-1])
                ? -bus.a : bus.a;
  assign b_mag  = (bus.signed_md & bus.b[WIDTH-1])
                ? -bus.b : bus.b;
  assign neg_in = bus.signed_md
                & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

  assign bus.in_ready = (state == IDLE);

  mul_fa_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .a    (acc[PW-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      mcand         <= '0;
      mplr          <= '0;
      neg           <= 1'b0;
      cnt           <= '0;
      bus.product   <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand    <= a_mag;
            mplr     <= b_mag;
            neg      <= neg_in;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_nxt[PW-1:1];
          mplr <= mplr >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            bus.product   <= neg ? -acc_nxt : acc_nxt;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed self-checking bench for seq_array_multiplier.
// Covers WIDTH=4 exhaustively and a few WIDTH=8 corners.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_array_multiplier_if #(.WIDTH(4)) b4 ();
  seq_array_multiplier_if #(.WIDTH(8)) b8 ();

  seq_array_multiplier #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  seq_array_multiplier #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref4(
    input logic [3:0] a, input logic [3:0] b,
    input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    return 8'(x * y);
  endfunction

  task automatic op4(input logic [3:0] a,
                     input logic [3:0] b,
                     input logic s, input bit take,
                     output logic [7:0] p,
                     output int lat);
    int n;
    n = 0;
    while (!b4.in_ready && n < 50) begin
      tick;
      n++;
    end
    b4.a = a;
    b4.b = b;
    b4.signed_md = s;
    b4.in_valid = 1'b1;
    tick;
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 50) begin
      tick;
      lat++;
    end
    p = b4.product;
    if (take) begin
      b4.out_ready = 1'b1;
      tick;
      b4.out_ready = 1'b0;
    end
  endtask

  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic s,
                     output logic [15:0] p,
                     output int lat);
    int n;
    n = 0;
    while (!b8.in_ready && n < 50) begin
      tick;
      n++;
    end
    b8.a = a;
    b8.b = b;
    b8.signed_md = s;
    b8.in_valid = 1'b1;
    tick;
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 50) begin
      tick;
      lat++;
    end
    p = b8.product;
    b8.out_ready = 1'b1;
    tick;
    b8.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  p;
    logic [15:0] p8;
    int          lat;
    bit          saw;

    rst = 1'b1;
    b4.in_valid = 1'b0;
    b4.signed_md = 1'b0;
    b4.a = '0;
    b4.b = '0;
    b4.out_ready = 1'b0;
    b8.in_valid = 1'b0;
    b8.signed_md = 1'b0;
    b8.a = '0;
    b8.b = '0;
    b8.out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", 32'(b4.in_ready), 32'd1);
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_busy", 32'(b4.busy), 32'd0);
    chk("rst_product", 32'(b4.product), 32'd0);
    rst = 1'b0;

    // 15*15 unsigned, latency 4, busy in DONE
    op4(4'hF, 4'hF, 1'b0, 1'b0, p, lat);
    chk("u15x15", 32'(p), 32'hE1);
    chk("u15x15_lat", 32'(lat), 32'd4);
    chk("done_busy", 32'(b4.busy), 32'd1);
    chk("done_in_ready", 32'(b4.in_ready), 32'd0);
    b4.out_ready = 1'b1;
    tick;
    b4.out_ready = 1'b0;
    chk("take_idle", 32'(b4.in_ready), 32'd1);

    op4(4'h8, 4'h8, 1'b1, 1'b1, p, lat);
    chk("s_m8xm8", 32'(p), 32'h40);
    op4(4'hD, 4'h5, 1'b1, 1'b1, p, lat);
    chk("s_m3x5", 32'(p), 32'hF1);
    op4(4'h7, 4'hF, 1'b1, 1'b1, p, lat);
    chk("s_7xm1", 32'(p), 32'hF9);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          op4(4'(a), 4'(b), 1'(s), 1'b1, p, lat);
          chk($sformatf("exh_s%0d_%0d_%0d", s, a, b),
              32'(p), 32'(ref4(4'(a), 4'(b), 1'(s))));
        end

    // backpressure: result held for 10 cycles
    op4(4'h6, 4'h7, 1'b0, 1'b0, p, lat);
    chk("bp_product", 32'(p), 32'h2A);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_hold", 32'(b4.product), 32'h2A);
      chk("bp_in_ready", 32'(b4.in_ready), 32'd0);
      chk("bp_valid", 32'(b4.out_valid), 32'd1);
    end
    b4.out_ready = 1'b1;
    tick;
    b4.out_ready = 1'b0;
    chk("bp_rel_ready", 32'(b4.in_ready), 32'd1);
    chk("bp_rel_valid", 32'(b4.out_valid), 32'd0);
    chk("bp_rel_busy", 32'(b4.busy), 32'd0);
    chk("bp_rel_prod", 32'(b4.product), 32'h2A);

    // in_valid during BUSY is ignored
    b4.a = 4'd2;
    b4.b = 4'd3;
    b4.signed_md = 1'b0;
    b4.in_valid = 1'b1;
    tick;
    b4.a = 4'd5;
    b4.b = 4'd5;
    tick;
    chk("ign_in_ready", 32'(b4.in_ready), 32'd0);
    tick;
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 50) begin
      tick;
      lat++;
    end
    chk("ign_product", 32'(b4.product), 32'd6);
    b4.out_ready = 1'b1;
    tick;
    b4.out_ready = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      saw = saw | b4.out_valid;
    end
    chk("ign_no_second", 32'(saw), 32'd0);

    // reset in BUSY at cnt=2
    b4.a = 4'd5;
    b4.b = 4'd6;
    b4.in_valid = 1'b1;
    tick;
    b4.in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_in_ready", 32'(b4.in_ready), 32'd1);
    chk("mrst_valid", 32'(b4.out_valid), 32'd0);
    chk("mrst_product", 32'(b4.product), 32'd0);
    chk("mrst_busy", 32'(b4.busy), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      saw = saw | b4.out_valid;
    end
    chk("mrst_no_result", 32'(saw), 32'd0);
    op4(4'd3, 4'd3, 1'b0, 1'b1, p, lat);
    chk("mrst_3x3", 32'(p), 32'd9);

    op8(8'hFF, 8'hFF, 1'b0, p8, lat);
    chk("w8_max", 32'(p8), 32'hFE01);
    chk("w8_lat", 32'(lat), 32'd8);
    op8(8'h00, 8'hC8, 1'b0, p8, lat);
    chk("w8_a0", 32'(p8), 32'h0000);
    op8(8'hC8, 8'h00, 1'b1, p8, lat);
    chk("w8_b0", 32'(p8), 32'h0000);
    op8(8'h80, 8'h80, 1'b1, p8, lat);
    chk("w8_minxmin", 32'(p8), 32'h4000);
    op8(8'h7F, 8'h80, 1'b1, p8, lat);
    chk("w8_maxxmin", 32'(p8), 32'hC080);
    op8(8'hFF, 8'h01, 1'b1, p8, lat);
    chk("w8_m1x1", 32'(p8), 32'hFFFF);
    op8(8'h7F, 8'h7F, 1'b1, p8, lat);
    chk("w8_maxxmax", 32'(p8), 32'h3F01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
